// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with a small TX FIFO and a pollable status word.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1); the default build sends 8N1.
module mmio_uart_tx #(
  parameter int          BAUD_DIV    = 434,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] TX_ADDR     = 32'h1001_0024,
  parameter logic [31:0] STATUS_ADDR = 32'h1001_0028
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        TxD,
  output logic        Busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [PTR_W:0]   FIFO_FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} txState_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} txState_t;
`endif

  txState_t         state;
  logic [7:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   fifoCount;
  logic [CNT_W-1:0] baudCnt;
  logic [2:0]       bitIdx;
  logic [7:0]       shiftReg;
  logic             txReg;
  logic             overflow;
`ifdef UART_TX_PARITY_EN
  logic             parityBit;
`endif

  logic       pushReq;
  logic       statusRd;
  logic       fifoFull;
  logic       fifoEmpty;
  logic       pushOk;
  logic       popReq;
  logic [7:0] headByte;
  logic       unusedWriteBits;

  assign pushReq   = MemWrite && (Address == TX_ADDR);
  assign statusRd  = MemRead && (Address == STATUS_ADDR);
  assign fifoFull  = (fifoCount == FIFO_FULL_COUNT);
  assign fifoEmpty = (fifoCount == '0);
  assign pushOk    = pushReq && !fifoFull;
  assign headByte  = fifoMem[rdPtr];
  assign unusedWriteBits = ^WriteData[31:8];

  // The FSM pops either from IDLE or straight out of STOP, so frames chain with no idle bit.
  assign popReq = !fifoEmpty && ((state == IDLE) || ((state == STOP) && (baudCnt == '0)));

  assign Busy     = (state != IDLE) || !fifoEmpty;
  assign TxD      = txReg;
  assign ReadData = statusRd ? {29'b0, overflow, fifoFull, Busy} : 32'b0;

  // Storage carries no reset; clearing the pointers is enough to discard queued bytes.
  always_ff @(posedge clk) begin
    if (pushOk) begin
      fifoMem[wrPtr] <= WriteData[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (pushOk) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (popReq) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({pushOk, popReq})
        2'b10:   fifoCount <= fifoCount + 1'b1;
        2'b01:   fifoCount <= fifoCount - 1'b1;
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  // A dropped push sets overflow even when a status read would clear it on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (pushReq && fifoFull) begin
      overflow <= 1'b1;
    end else if (statusRd) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      txReg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          txReg <= 1'b1;
          if (popReq) begin
            shiftReg <= headByte;
`ifdef UART_TX_PARITY_EN
            parityBit <= ^headByte;
`endif
            baudCnt <= BAUD_LAST;
            txReg   <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (baudCnt == '0) begin
            baudCnt <= BAUD_LAST;
            bitIdx  <= '0;
            txReg   <= shiftReg[0];
            state   <= DATA;
          end else begin
            baudCnt <= baudCnt - 1'b1;
          end
        end
        DATA: begin
          if (baudCnt == '0) begin
            baudCnt <= BAUD_LAST;
            if (bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              txReg <= parityBit;
              state <= PARITY;
`else
              txReg <= 1'b1;
              state <= STOP;
`endif
            end else begin
              shiftReg <= shiftReg >> 1;
              txReg    <= shiftReg[1];
              bitIdx   <= bitIdx + 3'd1;
            end
          end else begin
            baudCnt <= baudCnt - 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baudCnt == '0) begin
            baudCnt <= BAUD_LAST;
            txReg   <= 1'b1;
            state   <= STOP;
          end else begin
            baudCnt <= baudCnt - 1'b1;
          end
        end
`endif
        STOP: begin
          if (baudCnt == '0) begin
            if (popReq) begin
              shiftReg <= headByte;
`ifdef UART_TX_PARITY_EN
              parityBit <= ^headByte;
`endif
              baudCnt <= BAUD_LAST;
              txReg   <= 1'b0;
              state   <= START;
            end else begin
              txReg <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baudCnt <= baudCnt - 1'b1;
          end
        end
        default: begin
          txReg <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: table-driven bus checks plus a serial-line monitor fed by a byte scoreboard.
// Frame length follows UART_TX_PARITY_EN so the bench works for either build.
module tb_mmio_uart_tx;

  localparam int B     = 4;
  localparam int DEPTH = 4;
  localparam logic [31:0] TXA = 32'h1001_0024;
  localparam logic [31:0] STA = 32'h1001_0028;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] writeData = '0;
  logic        memWrite = 1'b0;
  logic        memRead = 1'b0;
  logic [31:0] readData;
  logic        txD;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  int   cycleCount = 0;
  logic [7:0] expQ[$];
  int   startQ[$];
  bit   monEnable = 1'b1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        rd;
    logic [31:0] expRead;
    logic        expBusy;
    logic        expTxD;
  } VecEntry;

  VecEntry vecs[10];

  mmio_uart_tx #(
    .BAUD_DIV(B),
    .FIFO_DEPTH(DEPTH),
    .TX_ADDR(TXA),
    .STATUS_ADDR(STA)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Address(address),
    .WriteData(writeData),
    .MemWrite(memWrite),
    .MemRead(memRead),
    .ReadData(readData),
    .TxD(txD),
    .Busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    address   = a;
    writeData = d;
    memWrite  = w;
    memRead   = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((expQ.size() != 0 || busy) && n < 2000);
    checkOutput({name, ".drained"}, 32'((expQ.size() == 0) && !busy), 32'd1);
    step();
  endtask

  // Serial monitor: samples each bit at its centre and scores the byte against the queue.
  initial begin : monitor
    logic [7:0] got;
    logic [7:0] expByte;
    forever begin
      @(negedge clk);
      if (monEnable && !reset && txD === 1'b0) begin
        startQ.push_back(cycleCount);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedFrame: got frame at cycle %0d, expected none", cycleCount);
          expByte = 8'h00;
        end else begin
          expByte = expQ.pop_front();
        end
        repeat (B / 2) @(negedge clk);
        checkOutput("startBit", 32'(txD), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          got[i] = txD;
        end
`ifdef UART_TX_PARITY_EN
        repeat (B) @(negedge clk);
        checkOutput("parityBit", 32'(txD), 32'(^expByte));
`endif
        repeat (B) @(negedge clk);
        checkOutput("stopBit", 32'(txD), 32'd1);
        checkOutput("frameByte", 32'(got), 32'(expByte));
      end
    end
  end

  initial begin : main
    int pushCycle;
    int base;

    vecs[0] = '{STA,      32'h00, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1};
    vecs[1] = '{TXA + 4,  32'hA3, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1};
    vecs[2] = '{TXA,      32'h00, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1};
    vecs[3] = '{STA,      32'h00, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1};
    vecs[4] = '{TXA,      32'h3C, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1};
    vecs[5] = '{STA,      32'h00, 1'b0, 1'b1, 32'd1, 1'b1, 1'b1};
    vecs[6] = '{32'h0,    32'h00, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0};
    vecs[7] = '{STA,      32'hFF, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0};
    vecs[8] = '{STA,      32'h00, 1'b0, 1'b1, 32'd1, 1'b1, 1'b0};
    vecs[9] = '{STA + 4,  32'h00, 1'b0, 1'b1, 32'd0, 1'b1, 1'b0};

    // Reset state, with a status read active so ReadData reflects the cleared registers.
    applyStimulus(STA, 0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset.TxD", 32'(txD), 32'd1);
    checkOutput("reset.Busy", 32'(busy), 32'd0);
    checkOutput("reset.status", readData, 32'd0);
    reset = 1'b0;
    applyStimulus(0, 0, 1'b0, 1'b0);
    step();

    // Single byte 0x55: start latency, TxD edges and Busy fall time.
    applyStimulus(TXA, 32'h55, 1'b1, 1'b0);
    expQ.push_back(8'h55);
    step();
    pushCycle = cycleCount;
    applyStimulus(0, 0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("lat.txdAtPush", 32'(txD), 32'd1);
    checkOutput("lat.busyAtPush", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("lat.txdStart", 32'(txD), 32'd0);
    while (cycleCount < pushCycle + FB * B) @(negedge clk);
    checkOutput("lat.busyLastCycle", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("lat.busyFallen", 32'(busy), 32'd0);
    checkOutput("lat.startCycle", 32'(startQ.size() > 0 ? startQ[startQ.size() - 1] - pushCycle : -1), 32'd1);
    waitIdle("single");

    // Table of bus cycles: decode, ignored accesses, push and status.
    for (int i = 0; i < $size(vecs); i++) begin
      applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].wr, vecs[i].rd);
      if (vecs[i].wr && vecs[i].addr == TXA) expQ.push_back(vecs[i].wdata[7:0]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d.ReadData", i), readData, vecs[i].expRead);
      checkOutput($sformatf("vec%0d.Busy", i), 32'(busy), 32'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d.TxD", i), 32'(txD), 32'(vecs[i].expTxD));
      step();
    end
    applyStimulus(0, 0, 1'b0, 1'b0);
    waitIdle("table");

    // Six back-to-back stores into a 4-deep FIFO: the sixth is dropped.
    base = startQ.size();
    for (int b = 1; b <= 6; b++) begin
      applyStimulus(TXA, 32'(b), 1'b1, 1'b0);
      if (b <= 5) expQ.push_back(8'(b));
      step();
    end
    applyStimulus(STA, 0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("ovf.status1", readData, 32'd7);
    step();
    @(negedge clk);
    checkOutput("ovf.status2", readData, 32'd3);
    step();
    applyStimulus(0, 0, 1'b0, 1'b0);
    waitIdle("overflow");
    checkOutput("ovf.frames", 32'(startQ.size() - base), 32'd5);
    if (startQ.size() - base >= 5) begin
      for (int j = 1; j < 5; j++) begin
        checkOutput($sformatf("ovf.gap%0d", j), 32'(startQ[base + j] - startQ[base + j - 1]), 32'(FB * B));
      end
    end
    applyStimulus(STA, 0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("ovf.statusIdle", readData, 32'd0);
    step();
    applyStimulus(0, 0, 1'b0, 1'b0);

    // Reset during data bit 3 of 0xFF aborts the frame asynchronously.
    monEnable = 1'b0;
    applyStimulus(TXA, 32'hFF, 1'b1, 1'b0);
    step();
    pushCycle = cycleCount;
    applyStimulus(0, 0, 1'b0, 1'b0);
    while (cycleCount < pushCycle + 1 + 4 * B + 1) @(negedge clk);
    @(negedge clk);
    checkOutput("rst.busyBefore", 32'(busy), 32'd1);
    applyStimulus(STA, 0, 1'b0, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("rst.TxD", 32'(txD), 32'd1);
    checkOutput("rst.Busy", 32'(busy), 32'd0);
    checkOutput("rst.status", readData, 32'd0);
    #1;
    reset = 1'b0;
    step();
    applyStimulus(0, 0, 1'b0, 1'b0);
    step();
    monEnable = 1'b1;
    applyStimulus(TXA, 32'h96, 1'b1, 1'b0);
    expQ.push_back(8'h96);
    step();
    applyStimulus(0, 0, 1'b0, 1'b0);
    waitIdle("afterReset");

    // Store landing on the STOP-exit edge of an empty FIFO: exactly one IDLE cycle in between.
    base = startQ.size();
    applyStimulus(TXA, 32'h21, 1'b1, 1'b0);
    expQ.push_back(8'h21);
    step();
    pushCycle = cycleCount;
    applyStimulus(0, 0, 1'b0, 1'b0);
    while (cycleCount < pushCycle + FB * B) step();
    applyStimulus(TXA, 32'h84, 1'b1, 1'b0);
    expQ.push_back(8'h84);
    step();
    applyStimulus(0, 0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("edge.idleTxD", 32'(txD), 32'd1);
    checkOutput("edge.idleBusy", 32'(busy), 32'd1);
    waitIdle("stopEdge");
    if (startQ.size() - base >= 2) begin
      checkOutput("edge.gap", 32'(startQ[base + 1] - startQ[base]), 32'(FB * B + 1));
    end else begin
      checkOutput("edge.frames", 32'(startQ.size() - base), 32'd2);
    end

    // Parity-sensitive bytes (odd and even popcount).
    applyStimulus(TXA, 32'h07, 1'b1, 1'b0);
    expQ.push_back(8'h07);
    step();
    applyStimulus(TXA, 32'h03, 1'b1, 1'b0);
    expQ.push_back(8'h03);
    step();
    applyStimulus(0, 0, 1'b0, 1'b0);
    waitIdle("parity");

    checkOutput("final.queueEmpty", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
